// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_arbiter
// Brief    : Two-requester round-robin arbiter that drives the select line of
//            a downstream 2:1 mux. A grant is held until its owner releases
//            its request. Handover between the two sources is direct, with
//            no idle cycle in between.
//            Optional build macro MUX_ARB_TIMEOUT_EN adds a hold-timeout:
//            once an owner has held the grant for MAX_HOLD cycles, a waiting
//            requester takes over and preempt pulses for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic select,
  output logic valid,
  output logic preempt
);

  // Each state bit is itself a grant flop, so gnt0/gnt1 come straight from
  // registers. The unused code 2'b11 is never entered.
  localparam logic [1:0] c_st_idle = 2'b00;
  localparam logic [1:0] c_st_g0   = 2'b01;
  localparam logic [1:0] c_st_g1   = 2'b10;

  // Catch an out-of-range hold limit at elaboration time.
  if ((MAX_HOLD < 1) || (MAX_HOLD > (2 ** CNT_W) - 1)) begin : g_bad_max_hold
    $error("mux_sel_arbiter: MAX_HOLD must be in 1 .. 2**CNT_W-1");
  end

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_last;       // most recent owner; the tie-break favours the other one
  logic       w_last_nxt;
  logic       r_select;
  logic       w_select_nxt;
  logic       r_valid;
  logic       w_force;      // forced handover is due at the next edge

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_preempt;
  logic             w_sat;

  assign w_sat   = (r_cnt == c_max_hold);
  // Only a requester that is actually waiting can take a saturated grant.
  assign w_force = w_sat && (((r_state == c_st_g0) && req1) ||
                             ((r_state == c_st_g1) && req0));

  // Hold counter: 1 on the first cycle of a grant, saturating count while the
  // same owner keeps the grant, and 0 while idle.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt == c_st_idle) begin
      w_cnt_nxt = '0;
    end else if (w_state_nxt != r_state) begin
      w_cnt_nxt = CNT_W'(1);
    end else if (!w_sat) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Counter and preempt registers; preempt marks the first cycle of a forced grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_preempt <= w_force;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: round-robin on ties, hold until release (or timeout).
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      c_st_idle: begin
        if (req0 && req1) begin
          w_state_nxt = r_last ? c_st_g0 : c_st_g1;
        end else if (req0) begin
          w_state_nxt = c_st_g0;
        end else if (req1) begin
          w_state_nxt = c_st_g1;
        end
      end
      c_st_g0: begin
        if (!req0 || w_force) begin
          w_last_nxt  = 1'b0;
          w_state_nxt = req1 ? c_st_g1 : c_st_idle;
        end
      end
      c_st_g1: begin
        if (!req1 || w_force) begin
          w_last_nxt  = 1'b1;
          w_state_nxt = req0 ? c_st_g0 : c_st_idle;
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // Select follows the next owner. While idle it keeps its previous value so
  // the mux path does not toggle.
  always_comb begin
    w_select_nxt = r_select;
    if (w_state_nxt == c_st_g0) begin
      w_select_nxt = 1'b0;
    end else if (w_state_nxt == c_st_g1) begin
      w_select_nxt = 1'b1;
    end
  end

  // Registered round-robin memory, select and valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last   <= 1'b1;
      r_select <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_last   <= w_last_nxt;
      r_select <= w_select_nxt;
      r_valid  <= (w_state_nxt != c_st_idle);
    end
  end

  // Output decode: every output is taken directly from a flop.
  always_comb begin
    gnt0   = r_state[0];
    gnt1   = r_state[1];
    select = r_select;
    valid  = r_valid;
`ifdef MUX_ARB_TIMEOUT_EN
    preempt = r_preempt;
`else
    preempt = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sel_arbiter
// Brief    : Self-checking bench for mux_sel_arbiter: directed vector table,
//            a hold-timeout sequence and a randomized run against an
//            owner-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_sel_arbiter;

  localparam int c_max_hold = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit c_tmo = 1'b1;
`else
  localparam bit c_tmo = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, req0, req1;
  logic gnt0, gnt1, select, valid, preempt;

  int checks = 0;
  int errors = 0;

  mux_sel_arbiter #(.MAX_HOLD(c_max_hold), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .gnt0(gnt0), .gnt1(gnt1), .select(select), .valid(valid), .preempt(preempt)
  );

  always #5 clk = ~clk;

  // Expected vector layout: {gnt0, gnt1, select, valid, preempt}
  typedef struct {
    logic       rst;
    logic       r0;
    logic       r1;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic r0, input logic r1,
                     input logic [4:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {gnt0,gnt1,sel,valid,preempt}=%b, expected %b", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then sample 1 time unit later.
  task automatic step(input logic rst, input logic r0, input logic r1);
    reset = rst; req0 = r0; req1 = r1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] outs();
    return {gnt0, gnt1, select, valid, preempt};
  endfunction

  // Reference model: the owner is -1 (nobody), 0 or 1.
  int m_owner, m_last, m_sel, m_hold;
  bit m_pre;

  task automatic model_step(input bit rst, input bit r0, input bit r1);
    bit req[2];
    int nxt;
    bit forced;
    req[0] = r0; req[1] = r1;
    if (rst) begin
      m_owner = -1; m_last = 1; m_sel = 0; m_hold = 0; m_pre = 0;
      return;
    end
    forced = 0;
    if (m_owner < 0) begin
      if (r0 && r1) nxt = 1 - m_last;
      else if (r0)  nxt = 0;
      else if (r1)  nxt = 1;
      else          nxt = -1;
    end else begin
      forced = c_tmo && (m_hold >= c_max_hold) && req[1 - m_owner];
      if (!req[m_owner] || forced) begin
        m_last = m_owner;
        nxt = req[1 - m_owner] ? 1 - m_owner : -1;
      end else begin
        nxt = m_owner;
      end
    end
    if (nxt < 0)             m_hold = 0;
    else if (nxt != m_owner) m_hold = 1;
    else                     m_hold = (m_hold + 1 > c_max_hold) ? c_max_hold : m_hold + 1;
    if (nxt >= 0) m_sel = nxt;
    m_pre   = forced;
    m_owner = nxt;
  endtask

  function automatic logic [4:0] model_outs();
    return {m_owner == 0, m_owner == 1, m_sel[0], m_owner >= 0, m_pre};
  endfunction

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] exp;
    bit rr, r0, r1;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;

    // ---- Directed table ----
    add(1, 1, 1, 5'b00000, "reset_hold_a");
    add(1, 1, 1, 5'b00000, "reset_hold_b");
    add(0, 1, 1, 5'b10010, "first_tie_g0");
    add(0, 1, 1, 5'b10010, "g0_held");
    add(0, 0, 1, 5'b01110, "handover_g1");
    add(0, 0, 1, 5'b01110, "g1_held");
    add(0, 0, 0, 5'b00100, "idle_keeps_sel1");
    add(0, 1, 1, 5'b10010, "tie_after_g1_g0");
    add(0, 0, 0, 5'b00000, "idle_sel0");
    add(0, 1, 1, 5'b01110, "tie_after_g0_g1");
    add(0, 1, 0, 5'b10010, "handover_g0");
    add(0, 0, 0, 5'b00000, "idle_again");
    add(0, 0, 1, 5'b01110, "g1_before_rst");
    add(1, 1, 1, 5'b00000, "mid_grant_reset");
    add(0, 1, 1, 5'b10010, "tie_after_reset");
    add(0, 0, 0, 5'b00000, "idle_after_tie");
    for (int i = 0; i < 5; i++) add(0, 0, 1, 5'b01110, $sformatf("single_req1_%0d", i));
    add(0, 0, 0, 5'b00100, "single_release");
    add(0, 0, 1, 5'b01110, "g1_again");
    add(0, 1, 1, 5'b01110, "req0_waits");
    add(0, 0, 0, 5'b00100, "req0_dropped_ignored");
    add(0, 0, 0, 5'b00100, "still_idle");

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].r0, tbl[i].r1);
      check(tbl[i].name, outs(), tbl[i].exp);
    end

    // ---- Hold-timeout sequence: req0 held, req1 joins on cycle 2 ----
    step(1, 0, 0);
    step(1, 0, 0);
    check("to_reset", outs(), 5'b00000);
    for (int i = 1; i <= 6; i++) begin
      step(0, 1, (i >= 2));
      if (c_tmo && i >= 5) exp = {4'b0111, (i == 5)};
      else                 exp = 5'b10010;
      check($sformatf("timeout_cyc%0d", i), outs(), exp);
    end
    step(0, 0, 0);
    check("timeout_release", outs(), c_tmo ? 5'b00100 : 5'b00000);

    // ---- Randomized run against the reference model ----
    r0 = 0; r1 = 0;
    for (int i = 0; i < 3000; i++) begin
      rr = (i == 0) || ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) r0 = ~r0;
      if ($urandom_range(0, 3) == 0) r1 = ~r1;
      step(rr, r0, r1);
      model_step(rr, r0, r1);
      check($sformatf("random_%0d", i), outs(), model_outs());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
